// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ALU command, shift type and NZCV index constants
package arm_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/val2_gen.sv
// rtl/val2_gen.sv - combinational second-operand former (rotated imm, mem offset, shifted Rm)
module val2_gen
    import arm_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] val_rm,
    input  logic [11:0]   shift_operand,
    input  logic          imm,
    input  logic          mem_en,
    output logic [DW-1:0] val2
);

    logic [DW-1:0]   imm_ext;
    logic [2*DW-1:0] imm_rot;
    logic [2*DW-1:0] rm_rot;
    logic [4:0]      sh_amt;
    logic [DW-1:0]   rm_shifted;

    assign imm_ext = {{(DW-8){1'b0}}, shift_operand[7:0]};
    // Rotation is done by shifting a doubled copy right and keeping the low half.
    assign imm_rot = {imm_ext, imm_ext} >> {shift_operand[11:8], 1'b0};
    assign sh_amt  = shift_operand[11:7];
    assign rm_rot  = {val_rm, val_rm} >> sh_amt;

    always_comb begin
        rm_shifted = val_rm;
        case (shift_operand[6:5])
            SH_LSL:  rm_shifted = val_rm << sh_amt;
            SH_LSR:  rm_shifted = val_rm >> sh_amt;
            SH_ASR:  rm_shifted = $signed(val_rm) >>> sh_amt;
            SH_ROR:  rm_shifted = rm_rot[DW-1:0];
            default: rm_shifted = val_rm;
        endcase
    end

    always_comb begin
        val2 = rm_shifted;
        if (imm)
            val2 = imm_rot[DW-1:0];
        else if (mem_en)
            val2 = {{(DW-12){1'b0}}, shift_operand};
    end

endmodule

// File: rtl/exe_stage_unit.sv
// rtl/exe_stage_unit.sv - execute stage: ALU, NZCV status register, branch target, EXE->MEM register
module exe_stage_unit
    import arm_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_en_in,
    input  logic          mem_read_en_in,
    input  logic          mem_write_en_in,
    input  logic          B_in,
    input  logic          S_in,
    input  logic [3:0]    exe_cmd_in,
    input  logic [DW-1:0] PC_in,
    input  logic [DW-1:0] val_Rn_in,
    input  logic [DW-1:0] val_Rm_in,
    input  logic [11:0]   shift_operand_in,
    input  logic          imm_in,
    input  logic [23:0]   signed_imm_24_in,
    input  logic [3:0]    dest_in,
    input  logic [3:0]    status_in,
    output logic [3:0]    status,
    output logic          branch_taken,
    output logic [DW-1:0] branch_addr,
    output logic          wb_en,
    output logic          mem_read_en,
    output logic          mem_write_en,
    output logic [DW-1:0] alu_res,
    output logic [DW-1:0] val_Rm,
    output logic [3:0]    dest
);

    logic [DW-1:0] val2;
    logic [DW-1:0] b_op;
    logic [DW-1:0] alu_out;
    logic [DW:0]   sum;
    logic          cin;
    logic          arith;
    logic          flag_upd;
    logic [3:0]    new_flags;
    logic [DW-1:0] off_ext;

    val2_gen #(.DW(DW)) u_val2_gen (
        .val_rm        (val_Rm_in),
        .shift_operand (shift_operand_in),
        .imm           (imm_in),
        .mem_en        (mem_read_en_in | mem_write_en_in),
        .val2          (val2)
    );

    // Subtraction is Rn + ~Val2 + carry-in, so C comes out as NOT borrow directly.
    always_comb begin
        alu_out  = '0;
        b_op     = val2;
        cin      = 1'b0;
        arith    = 1'b0;
        flag_upd = 1'b1;
        case (exe_cmd_in)
            EXE_MOV: alu_out = val2;
            EXE_MVN: alu_out = ~val2;
            EXE_ADD: arith = 1'b1;
            EXE_ADC: begin arith = 1'b1; cin = status_in[FLG_C]; end
            EXE_SUB: begin arith = 1'b1; b_op = ~val2; cin = 1'b1; end
            EXE_SBC: begin arith = 1'b1; b_op = ~val2; cin = status_in[FLG_C]; end
            EXE_AND: alu_out = val_Rn_in & val2;
            EXE_ORR: alu_out = val_Rn_in | val2;
            EXE_EOR: alu_out = val_Rn_in ^ val2;
            default: flag_upd = 1'b0;
        endcase
        sum = {1'b0, val_Rn_in} + {1'b0, b_op} + {{DW{1'b0}}, cin};
        if (arith)
            alu_out = sum[DW-1:0];

        new_flags        = status_in;
        new_flags[FLG_N] = alu_out[DW-1];
        new_flags[FLG_Z] = (alu_out == '0);
        if (arith) begin
            new_flags[FLG_C] = sum[DW];
            new_flags[FLG_V] = (val_Rn_in[DW-1] == b_op[DW-1]) && (alu_out[DW-1] != val_Rn_in[DW-1]);
        end
    end

    assign off_ext      = {{(DW-24){signed_imm_24_in[23]}}, signed_imm_24_in};
    assign branch_taken = B_in;
    assign branch_addr  = PC_in + (off_ext << 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status       <= '0;
            wb_en        <= 1'b0;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            alu_res      <= '0;
            val_Rm       <= '0;
            dest         <= '0;
        end else begin
            if (S_in && flag_upd)
                status <= new_flags;
            wb_en        <= wb_en_in;
            mem_read_en  <= mem_read_en_in;
            mem_write_en <= mem_write_en_in;
            alu_res      <= alu_out;
            val_Rm       <= val_Rm_in;
            dest         <= dest_in;
        end
    end

endmodule
